// File: rtl/pmem_boot_controller_pkg.sv
// Shared types for the program-memory boot controller: FSM states, byte width
// and the default instruction word type.
package pmem_boot_controller_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } boot_state_t;

endpackage

// File: rtl/pmem_boot_controller_byte_word_assembler.sv
// Packs a byte stream into little-endian words; lane 0 lands in bits 7:0.
// word_ready flags the byte that completes a word.
module byte_word_assembler
  import pmem_boot_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  word_ready,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  logic [IDX_W-1:0] byte_idx;

  // clear wins over a simultaneous byte so an aborted word never completes
  assign word_ready = byte_en && !clear && (byte_idx == LAST_LANE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (byte_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_idx == IDX_W'(i)) word[i*BYTE_WIDTH +: BYTE_WIDTH] <= byte_data;
      end
      byte_idx <= word_ready ? '0 : byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pmem_boot_controller.sv
// Arbitrates the single program-memory port between combinational instruction
// fetch and a byte-stream boot loader that writes consecutive words.
module pmem_boot_controller
  import pmem_boot_controller_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     boot_start,
  input  logic [ADDRESS_WIDTH-1:0] boot_base,
  input  logic [ADDRESS_WIDTH:0]   boot_words,
  input  logic                     boot_abort,
  input  logic                     byte_valid,
  input  logic [BYTE_WIDTH-1:0]    byte_data,
  output logic                     byte_ready,
  input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  output logic                     fetch_valid,
  output logic                     cpu_stall,
  output logic                     load_done,
  output logic                     load_busy,
  output logic                     mem_write_en,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  localparam int MEMORY_DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);

  boot_state_t              state, state_next;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH:0]   words_left;
  logic                     start_go;
  logic                     abort_act;
  logic                     word_ready;
  logic [DATA_WIDTH-1:0]    asm_word;

  byte_word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_go || abort_act),
    .byte_en   (byte_ready && byte_valid),
    .byte_data (byte_data),
    .word_ready(word_ready),
    .word      (asm_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      words_left <= '0;
    end else begin
      state <= state_next;
      if (start_go) begin
        wr_ptr     <= boot_base;
        words_left <= (boot_words > DEPTH_CNT) ? DEPTH_CNT : boot_words;
      end else if (mem_write_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        words_left <= words_left - 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    byte_ready   = 1'b0;
    mem_write_en = 1'b0;
    load_done    = 1'b0;
    load_busy    = 1'b1;
    cpu_stall    = 1'b1;
    fetch_valid  = 1'b0;
    mem_address  = wr_ptr;
    start_go     = 1'b0;
    abort_act    = 1'b0;
    case (state)
      IDLE: begin
        load_busy   = 1'b0;
        cpu_stall   = 1'b0;
        fetch_valid = 1'b1;
        mem_address = fetch_addr;
        if (boot_start && (boot_words != '0)) begin
          start_go   = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        if (boot_abort) begin
          abort_act  = 1'b1;
          state_next = IDLE;
        end else if (word_ready) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (boot_abort) begin
          abort_act  = 1'b1;
          state_next = IDLE;
        end else begin
          mem_write_en = 1'b1;
          state_next   = (words_left == 1) ? DONE : RECV;
        end
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fetch_data     = fetch_valid ? mem_read_data : '0;
  assign mem_write_data = asm_word;

endmodule
